// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the data RAM arbiter.
package data_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    CLEAR   = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Combinational two-way pick: round-robin against last_gnt, or fixed port-0 priority.
module data_ram_arbiter_rr_arb2
  import data_ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  input  logic prio_fixed,
  output logic sel,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    sel   = PORT_CPU;
    if (req0 && req1) begin
      sel = prio_fixed ? PORT_CPU : other_port(last_gnt);
    end else if (req1) begin
      sel = PORT_LDR;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single data RAM port between the CPU (port 0) and the loader (port 1),
// sequences reads/writes/whole-RAM clear, and returns read data with a valid pulse.
//
// state   | meaning
// IDLE    | RAM disabled, arbitrating every cycle
// ACCESS  | RAM performing the granted op; writes re-arbitrate here
// CAPTURE | registered RAM dataout is valid; sample it, pulse rvld, arbitrate
// CLEAR   | RAM clear strobe was issued last edge; pulse clr_done, arbitrate
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int unsigned A          = 8,
  parameter int unsigned W          = 8,
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [A-1:0] addr0,
  input  logic [A-1:0] addr1,
  input  logic [W-1:0] wdat0,
  input  logic [W-1:0] wdat1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rvld0,
  output logic         rvld1,
  output logic         wack0,
  output logic         wack1,
  output logic [W-1:0] rdata,
  input  logic         clr_req,
  output logic         clr_done,
  output logic         ram_en,
  output logic         ram_rd,
  output logic         ram_wr,
  output logic         ram_clr_n,
  output logic [A-1:0] ram_addr,
  output logic [W-1:0] ram_din,
  input  logic [W-1:0] ram_dout
);

  arb_state_e   state_q, state_d;
  logic         port_q, port_d;
  logic         last_gnt_q, last_gnt_d;
  logic         arb_ok;
  logic         arb_sel, arb_valid;

  logic         gnt0_d, gnt1_d, rvld0_d, rvld1_d, wack0_d, wack1_d, clr_done_d;
  logic         ram_en_d, ram_rd_d, ram_wr_d, ram_clr_n_d;
  logic [A-1:0] ram_addr_d;
  logic [W-1:0] ram_din_d, rdata_d;

  data_ram_arbiter_rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_gnt   (last_gnt_q),
    .prio_fixed (PRIO_FIXED != 0),
    .sel        (arb_sel),
    .valid      (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    last_gnt_d  = last_gnt_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvld0_d     = 1'b0;
    rvld1_d     = 1'b0;
    wack0_d     = 1'b0;
    wack1_d     = 1'b0;
    clr_done_d  = 1'b0;
    ram_en_d    = 1'b0;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_clr_n_d = 1'b1;
    ram_addr_d  = ram_addr;
    ram_din_d   = ram_din;
    rdata_d     = rdata;
    arb_ok      = 1'b0;

    case (state_q)
      IDLE: arb_ok = 1'b1;
      ACCESS: begin
        // ram_wr still holds the granted op's direction during ACCESS
        if (ram_wr) begin
          if (port_q == PORT_CPU) wack0_d = 1'b1;
          else                    wack1_d = 1'b1;
          arb_ok = 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_d = ram_dout;
        if (port_q == PORT_CPU) rvld0_d = 1'b1;
        else                    rvld1_d = 1'b1;
        arb_ok = 1'b1;
      end
      CLEAR: begin
        clr_done_d = 1'b1;
        arb_ok     = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (arb_ok) begin
      if (clr_req) begin
        state_d     = CLEAR;
        ram_clr_n_d = 1'b0;
      end else if (arb_valid) begin
        state_d    = ACCESS;
        port_d     = arb_sel;
        last_gnt_d = arb_sel;
        ram_en_d   = 1'b1;
        if (arb_sel == PORT_CPU) begin
          gnt0_d     = 1'b1;
          ram_addr_d = addr0;
          ram_din_d  = wdat0;
          ram_wr_d   = we0;
          ram_rd_d   = ~we0;
        end else begin
          gnt1_d     = 1'b1;
          ram_addr_d = addr1;
          ram_din_d  = wdat1;
          ram_wr_d   = we1;
          ram_rd_d   = ~we1;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      port_q     <= PORT_CPU;
      last_gnt_q <= PORT_LDR;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvld0      <= 1'b0;
      rvld1      <= 1'b0;
      wack0      <= 1'b0;
      wack1      <= 1'b0;
      clr_done   <= 1'b0;
      ram_en     <= 1'b0;
      ram_rd     <= 1'b0;
      ram_wr     <= 1'b0;
      ram_clr_n  <= 1'b1;
      ram_addr   <= '0;
      ram_din    <= '0;
      rdata      <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      last_gnt_q <= last_gnt_d;
      gnt0       <= gnt0_d;
      gnt1       <= gnt1_d;
      rvld0      <= rvld0_d;
      rvld1      <= rvld1_d;
      wack0      <= wack0_d;
      wack1      <= wack1_d;
      clr_done   <= clr_done_d;
      ram_en     <= ram_en_d;
      ram_rd     <= ram_rd_d;
      ram_wr     <= ram_wr_d;
      ram_clr_n  <= ram_clr_n_d;
      ram_addr   <= ram_addr_d;
      ram_din    <= ram_din_d;
      rdata      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: one round-robin and one fixed-priority instance, each with a RAM model.
module tb_data_ram_arbiter;

  typedef struct {
    int         port;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdat;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         port;
    bit         we;
    logic [7:0] exp;
    int         due;
  } pend_t;

  logic       clk = 1'b0;
  logic       clear;
  logic       req   [2][2];
  logic       we    [2][2];
  logic [7:0] addr  [2][2];
  logic [7:0] wdat  [2][2];
  logic       gnt   [2][2];
  logic       rvld  [2][2];
  logic       wack  [2][2];
  logic [7:0] rdata [2];
  logic       clr_req [2];
  logic       clr_done [2];
  logic       ram_en [2];
  logic       ram_rd [2];
  logic       ram_wr [2];
  logic       ram_clr_n [2];
  logic [7:0] ram_addr [2];
  logic [7:0] ram_din [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [256];
    logic [7:0] dout_q;

    data_ram_arbiter #(.A(8), .W(8), .PRIO_FIXED(g)) u_dut (
      .clk(clk), .clear(clear),
      .req0(req[g][0]), .req1(req[g][1]), .we0(we[g][0]), .we1(we[g][1]),
      .addr0(addr[g][0]), .addr1(addr[g][1]), .wdat0(wdat[g][0]), .wdat1(wdat[g][1]),
      .gnt0(gnt[g][0]), .gnt1(gnt[g][1]), .rvld0(rvld[g][0]), .rvld1(rvld[g][1]),
      .wack0(wack[g][0]), .wack1(wack[g][1]), .rdata(rdata[g]),
      .clr_req(clr_req[g]), .clr_done(clr_done[g]),
      .ram_en(ram_en[g]), .ram_rd(ram_rd[g]), .ram_wr(ram_wr[g]), .ram_clr_n(ram_clr_n[g]),
      .ram_addr(ram_addr[g]), .ram_din(ram_din[g]), .ram_dout(dout_q)
    );

    // RAM with registered dataout and active-low synchronous clear
    always @(posedge clk) begin
      if (!ram_clr_n[g]) begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (ram_en[g]) begin
        if (ram_wr[g]) mem[ram_addr[g]] <= ram_din[g];
        if (ram_rd[g]) dout_q <= mem[ram_addr[g]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input int d, input string nm);
    chk({nm, " ctl"}, {ram_en[d], ram_rd[d], ram_wr[d], ram_clr_n[d], clr_done[d],
        gnt[d][0], gnt[d][1], rvld[d][0], rvld[d][1], wack[d][0], wack[d][1]}, 11'b00010000000);
    chk({nm, " ram_addr"}, ram_addr[d], 0);
    chk({nm, " ram_din"}, ram_din[d], 0);
    chk({nm, " rdata"}, rdata[d], 0);
  endtask

  task automatic do_reset();
    @(negedge clk) clear = 1'b0;
    @(negedge clk) clear = 1'b1;
  endtask

  // Single transaction on one port; call at a negedge.
  task automatic xact(input int d, input int p, input bit w, input logic [7:0] a,
                      input logic [7:0] wd, input logic [7:0] ex, input string nm);
    bit got;
    req[d][p] = 1'b1; we[d][p] = w; addr[d][p] = a; wdat[d][p] = wd;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = gnt[d][p];
    end
    chk({nm, " gnt"}, got, 1);
    req[d][p] = 1'b0;
    if (got) begin
      chk({nm, " other gnt"}, gnt[d][1-p], 0);
      chk({nm, " ram ctl"}, {ram_en[d], ram_rd[d], ram_wr[d]}, {1'b1, ~w, w});
      chk({nm, " ram_addr"}, ram_addr[d], a);
      if (w) begin
        chk({nm, " ram_din"}, ram_din[d], wd);
        @(negedge clk);
        chk({nm, " wack E+1"}, wack[d][p], 1);
      end else begin
        @(negedge clk);
        chk({nm, " rvld early"}, rvld[d][p], 0);
        @(negedge clk);
        chk({nm, " rvld E+2"}, rvld[d][p], 1);
        chk({nm, " rdata"}, rdata[d], ex);
      end
    end
  endtask

  task automatic t_table();
    vec_t tbl [9];
    tbl[0] = '{0, 1'b1, 8'h10, 8'h5A, 8'h00};
    tbl[1] = '{0, 1'b0, 8'h10, 8'h00, 8'h5A};
    tbl[2] = '{1, 1'b1, 8'hFF, 8'hA5, 8'h00};
    tbl[3] = '{0, 1'b0, 8'hFF, 8'h00, 8'hA5};
    tbl[4] = '{1, 1'b1, 8'h00, 8'h3C, 8'h00};
    tbl[5] = '{1, 1'b0, 8'h00, 8'h00, 8'h3C};
    tbl[6] = '{0, 1'b1, 8'h10, 8'h00, 8'h00};
    tbl[7] = '{1, 1'b0, 8'h10, 8'h00, 8'h00};
    tbl[8] = '{1, 1'b0, 8'hFF, 8'h00, 8'hA5};
    for (int i = 0; i < 9; i++)
      xact(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdat, tbl[i].exp,
           $sformatf("tbl[%0d]", i));
  endtask

  task automatic t_reset_mid();
    bit got;
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 8'h10;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = gnt[0][0];
    end
    chk("rst-mid gnt", got, 1);
    req[0][0] = 1'b0;
    #2 clear = 1'b0;
    #1;
    check_idle(0, "rst-mid dut0");
    check_idle(1, "rst-mid dut1");
    @(negedge clk) clear = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("rst-mid no rvld", {rvld[0][0], ram_en[0]}, 0);
    end
  endtask

  task automatic t_rr();
    int exp_port, ngnt, nrv;
    xact(0, 0, 1'b1, 8'h17, 8'h1E, 8'h00, "rr preload0");
    xact(0, 1, 1'b1, 8'h20, 8'h00, 8'h00, "rr preload1");
    do_reset();
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 8'h17;
    req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 8'h20;
    exp_port = 0; ngnt = 0; nrv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (gnt[0][0] || gnt[0][1]) begin
        chk("rr order", {gnt[0][1], gnt[0][0]}, (exp_port == 1) ? 2'b10 : 2'b01);
        exp_port = 1 - exp_port;
        ngnt++;
        if (ngnt == 6) begin req[0][0] = 1'b0; req[0][1] = 1'b0; end
      end
      if (rvld[0][0]) begin chk("rr rdata0", rdata[0], 8'h1E); nrv++; end
      if (rvld[0][1]) begin chk("rr rdata1", rdata[0], 8'h00); nrv++; end
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    chk("rr grants", ngnt, 6);
    chk("rr rvlds", nrv, 6);
  endtask

  task automatic t_fixed();
    int n_g0, n_g1;
    bit got;
    do_reset();
    n_g0 = 0; n_g1 = 0;
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 8'h01;
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 8'h02;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt[1][0]) n_g0++;
      if (gnt[1][1]) n_g1++;
    end
    chk("fixed gnt1 while req0", n_g1, 0);
    chk("fixed gnt0 count", n_g0, 10);
    req[1][0] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge clk);
      got = gnt[1][1];
    end
    chk("fixed gnt1 after release", got, 1);
    req[1][1] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic t_stream();
    bit got;
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 8'h30; wdat[0][1] = 8'h00;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      got = gnt[0][1];
    end
    chk("stream first gnt", got, 1);
    for (int i = 1; i <= 8; i++) begin
      if (i < 8) begin
        addr[0][1] = 8'h30 + 8'(i);
        wdat[0][1] = 8'(i);
      end else begin
        req[0][1] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("stream wack %0d", i - 1), wack[0][1], 1);
      if (i < 8) chk($sformatf("stream gnt %0d", i), gnt[0][1], 1);
    end
    for (int i = 0; i < 8; i++)
      xact(0, 0, 1'b0, 8'h30 + 8'(i), 8'h00, 8'(i), $sformatf("stream readback %0d", i));
  endtask

  task automatic t_clear();
    xact(0, 0, 1'b1, 8'h10, 8'h77, 8'h00, "clr preload");
    clr_req[0] = 1'b1;
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 8'h10;
    @(negedge clk);
    chk("clr strobe", {ram_clr_n[0], ram_en[0], gnt[0][0]}, 3'b000);
    clr_req[0] = 1'b0;
    @(negedge clk);
    chk("clr done+gnt0", {clr_done[0], gnt[0][0], ram_clr_n[0]}, 3'b111);
    req[0][0] = 1'b0;
    @(negedge clk);
    chk("clr done one-shot", {clr_done[0], rvld[0][0]}, 2'b00);
    @(negedge clk);
    chk("clr read rvld", rvld[0][0], 1);
    chk("clr read data", rdata[0], 8'h00);
  endtask

  task automatic t_random();
    pend_t      e;
    pend_t      q[$];
    logic [7:0] mmem [256];
    logic [7:0] m_rdata;
    logic [1:0] exp_w, exp_r, g;
    int         last_m, p, clr_due, max_age, n_gnt;
    int         age [2];
    do_reset();
    clr_req[0] = 1'b1;
    for (int n = 0; n < 5 && clr_req[0]; n++) begin
      @(negedge clk);
      if (!ram_clr_n[0]) clr_req[0] = 1'b0;
    end
    clr_req[0] = 1'b0;
    @(negedge clk);
    chk("rnd init clr_done", clr_done[0], 1);
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    last_m = 1; m_rdata = 8'h00; clr_due = -1; max_age = 0; n_gnt = 0;
    age[0] = 0; age[1] = 0;

    for (int cyc = 1; cyc <= 3006; cyc++) begin
      @(negedge clk);
      exp_w = 2'b00; exp_r = 2'b00;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.we) exp_w[e.port] = 1'b1;
        else begin exp_r[e.port] = 1'b1; m_rdata = e.exp; end
      end
      chk("rnd wack", {wack[0][1], wack[0][0]}, exp_w);
      chk("rnd rvld", {rvld[0][1], rvld[0][0]}, exp_r);
      chk("rnd rdata", rdata[0], m_rdata);
      chk("rnd clr_done", clr_done[0], clr_due == cyc);

      g = {gnt[0][1], gnt[0][0]};
      chk("rnd gnt both", g == 2'b11, 0);
      if (g != 2'b00) begin
        p = g[1] ? 1 : 0;
        n_gnt++;
        chk("rnd gnt without req", req[0][p], 1);
        chk("rnd clr priority", clr_req[0], 0);
        if (req[0][0] && req[0][1]) chk("rnd rr pick", p, 1 - last_m);
        last_m = p;
        chk("rnd ram_addr", ram_addr[0], addr[0][p]);
        chk("rnd ram ctl", {ram_en[0], ram_rd[0], ram_wr[0]}, {1'b1, ~we[0][p], we[0][p]});
        e.port = p;
        e.we   = we[0][p];
        e.due  = cyc + (we[0][p] ? 1 : 2);
        e.exp  = we[0][p] ? 8'h00 : mmem[addr[0][p]];
        if (we[0][p]) mmem[addr[0][p]] = wdat[0][p];
        q.push_back(e);
        req[0][p] = 1'b0;
        age[p] = 0;
      end

      if (!ram_clr_n[0]) begin
        chk("rnd clr without req", clr_req[0], 1);
        for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
        clr_due = cyc + 1;
        clr_req[0] = 1'b0;
      end

      for (int k = 0; k < 2; k++) begin
        if (req[0][k]) begin
          age[k]++;
          if (age[k] > max_age) max_age = age[k];
        end else if (cyc <= 3000 && ($urandom % 3) == 0) begin
          req[0][k]  = 1'b1;
          we[0][k]   = 1'($urandom % 2);
          addr[0][k] = (($urandom % 8) == 0) ? 8'hFF : 8'($urandom % 16);
          wdat[0][k] = 8'($urandom);
          age[k]     = 0;
        end
      end
      if (cyc <= 3000 && !clr_req[0] && ($urandom % 60) == 0) clr_req[0] = 1'b1;
    end
    chk("rnd drained", q.size(), 0);
    chk("rnd max wait ok", max_age <= 12, 1);
    chk("rnd enough grants", n_gnt > 500, 1);
  endtask

  initial begin
    clear = 1'b1;
    for (int d = 0; d < 2; d++) begin
      clr_req[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = 8'h00; wdat[d][p] = 8'h00;
      end
    end
    #3 clear = 1'b0;
    @(negedge clk);
    check_idle(0, "reset dut0");
    check_idle(1, "reset dut1");
    clear = 1'b1;
    t_table();
    t_reset_mid();
    t_rr();
    t_fixed();
    t_stream();
    t_clear();
    t_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
